// File: rtl/hazard_control_unit_pkg.sv
// Shared types and constants for the hazard control unit.
// Opcodes are instr[6:2]; forwarding codes select the ALU operand source.
package hazard_control_unit_pkg;

    localparam logic [4:0] OP_R     = 5'b01100;
    localparam logic [4:0] OP_I     = 5'b00100;
    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_JALR  = 5'b11001;
    localparam logic [4:0] OP_S     = 5'b01000;
    localparam logic [4:0] OP_B     = 5'b11000;
    localparam logic [4:0] OP_AUIPC = 5'b00101;
    localparam logic [4:0] OP_LUI   = 5'b01101;
    localparam logic [4:0] OP_JAL   = 5'b11011;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
    } stage_t;

    typedef struct packed {
        stage_t     base;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses_rs1;
        logic       uses_rs2;
    } ex_stage_t;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       uses_rs1;
        logic       uses_rs2;
        logic       writes_rd;
        logic       is_load;
    } dec_t;

    // Loads in MEM have no data yet, so only WB may forward them.
    function automatic logic [1:0] fwd_sel(
        input logic       uses,
        input logic [4:0] rs,
        input stage_t     mem,
        input stage_t     wb
    );
        if (uses && mem.valid && mem.regwrite &&
            !mem.memread && mem.rd == rs)
            return FWD_MEM;
        if (uses && wb.valid && wb.regwrite && wb.rd == rs)
            return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_control_unit_decode.sv
// Register-usage decoder for the instruction sitting in Decode.
// All flags collapse to 0 for a bubble.
module hazard_decode
    import hazard_control_unit_pkg::*;
(
    input  logic [31:0] instr,
    input  logic        valid,
    output dec_t        dec
);

    logic [4:0] opc;
    logic       unused_bits;

    assign opc = instr[6:2];
    assign unused_bits = ^{instr[31:25], instr[14:12], instr[1:0]};

    always_comb begin
        dec           = '0;
        dec.rs1       = instr[19:15];
        dec.rs2       = instr[24:20];
        dec.rd        = instr[11:7];
        dec.uses_rs1  = valid && (opc inside
            {OP_R, OP_I, OP_LOAD, OP_JALR, OP_S, OP_B});
        dec.uses_rs2  = valid && (opc inside {OP_R, OP_S, OP_B});
        dec.writes_rd = valid && (dec.rd != 5'd0) && (opc inside
            {OP_R, OP_I, OP_LOAD, OP_JALR, OP_AUIPC, OP_LUI, OP_JAL});
        dec.is_load   = valid && (opc == OP_LOAD);
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Stall, flush and forwarding control for a 5-stage RISC-V pipeline.
// Shadows EX/MEM/WB register usage and keeps saturating event counters.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter logic [15:0] CNT_SAT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] id_instr,
    input  logic        id_valid,
    input  logic        ex_redirect,
    input  logic        mem_busy,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    dec_t      dec;
    ex_stage_t ex_q;
    ex_stage_t ex_d;
    stage_t    mem_q;
    stage_t    wb_q;
    logic      load_use;
    logic      redirect;
    logic      sel_busy;
    logic      sel_redir;
    logic      sel_lu;
    logic      unused_wb;

    hazard_decode u_dec (
        .instr (id_instr),
        .valid (id_valid),
        .dec   (dec)
    );

    assign unused_wb = wb_q.memread;

    assign load_use = ex_q.base.valid && ex_q.base.memread &&
                      (ex_q.base.rd != 5'd0) &&
                      ((dec.uses_rs1 && dec.rs1 == ex_q.base.rd) ||
                       (dec.uses_rs2 && dec.rs2 == ex_q.base.rd));

    assign redirect = ex_redirect && ex_q.base.valid;

    // One-hot winner; reset leaves every select low.
    assign sel_busy  = !rst && mem_busy;
    assign sel_redir = !rst && !mem_busy && redirect;
    assign sel_lu    = !rst && !mem_busy && !redirect && load_use;

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        unique case (1'b1)
            sel_busy: begin
                pc_en   = 1'b0;
                ifid_en = 1'b0;
            end
            sel_redir: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end
            sel_lu: begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        ex_d = '0;
        if (!idex_flush) begin
            ex_d.base.valid    = id_valid;
            ex_d.base.rd       = dec.rd;
            ex_d.base.regwrite = dec.writes_rd;
            ex_d.base.memread  = dec.is_load;
            ex_d.rs1           = dec.rs1;
            ex_d.rs2           = dec.rs2;
            ex_d.uses_rs1      = dec.uses_rs1;
            ex_d.uses_rs2      = dec.uses_rs2;
        end
    end

    assign fwd_a = (rst || !ex_q.base.valid) ? FWD_RF :
                   fwd_sel(ex_q.uses_rs1, ex_q.rs1, mem_q, wb_q);
    assign fwd_b = (rst || !ex_q.base.valid) ? FWD_RF :
                   fwd_sel(ex_q.uses_rs2, ex_q.rs2, mem_q, wb_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!mem_busy) begin
            wb_q  <= mem_q;
            mem_q <= ex_q.base;
            ex_q  <= ex_d;
            if (sel_lu && stall_cnt != CNT_SAT)
                stall_cnt <= stall_cnt + 16'd1;
            if (sel_redir && flush_cnt != CNT_SAT)
                flush_cnt <= flush_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit with a stage-occupancy model.
// Counter saturation point is lowered to keep the run short.
module tb_hazard_control_unit;

    localparam logic [15:0] SAT = 16'h00FF;

    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [31:0] LW5   = 32'h0000A283;
    localparam logic [31:0] LW55  = 32'h0002A283;
    localparam logic [31:0] ADD6  = 32'h00228333;
    localparam logic [31:0] ADDI3 = 32'h00700193;
    localparam logic [31:0] SUB4  = 32'h40318233;
    localparam logic [31:0] ADDI0 = 32'h00100013;
    localparam logic [31:0] ADD7  = 32'h000003B3;
    localparam logic [31:0] BEQ   = 32'h00208063;
    localparam logic [31:0] ADDI8 = 32'h00100413;
    localparam logic [31:0] ADD9  = 32'h008404B3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        ex_redirect;
    logic        mem_busy;
    logic        pc_en;
    logic        ifid_en;
    logic        ifid_flush;
    logic        idex_flush;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 0;

    // Model: index 0 = EX, 1 = MEM, 2 = WB
    bit         mv[3];
    logic [4:0] mrd[3];
    bit         mwr[3];
    bit         mld[3];
    logic [4:0] xrs1, xrs2;
    bit         xu1, xu2;
    int         mstall, mflush;

    typedef struct packed {
        logic       pc_en;
        logic       ifid_en;
        logic       ifid_flush;
        logic       idex_flush;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [1:0] win;
    } exp_t;

    hazard_control_unit #(.CNT_SAT(SAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_instr    (id_instr),
        .id_valid    (id_valid),
        .ex_redirect (ex_redirect),
        .mem_busy    (mem_busy),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h",
                     name, $time, act, exp);
        end
    endtask

    function automatic void dec(
        input  logic [31:0] i,
        input  logic        v,
        output logic [4:0]  r1,
        output logic [4:0]  r2,
        output logic [4:0]  rd,
        output bit          u1,
        output bit          u2,
        output bit          wr,
        output bit          ld
    );
        logic [4:0] op;
        op = i[6:2];
        r1 = i[19:15];
        r2 = i[24:20];
        rd = i[11:7];
        u1 = v && (op inside {5'b01100, 5'b00100, 5'b00000,
                              5'b11001, 5'b01000, 5'b11000});
        u2 = v && (op inside {5'b01100, 5'b01000, 5'b11000});
        wr = v && rd != 0 && (op inside {5'b01100, 5'b00100,
                  5'b00000, 5'b11001, 5'b00101, 5'b01101, 5'b11011});
        ld = v && op == 5'b00000;
    endfunction

    function automatic logic [1:0] mfwd(input bit u,
                                        input logic [4:0] rs);
        if (rst || !mv[0] || !u) return 2'd0;
        if (mv[1] && mwr[1] && !mld[1] && mrd[1] == rs) return 2'd1;
        if (mv[2] && mwr[2] && mrd[2] == rs) return 2'd2;
        return 2'd0;
    endfunction

    // win: 0 normal/reset, 1 busy, 2 redirect, 3 load-use
    function automatic exp_t expect_now();
        exp_t e;
        logic [4:0] r1, r2, rd;
        bit u1, u2, wr, ld, lu;
        dec(id_instr, id_valid, r1, r2, rd, u1, u2, wr, ld);
        lu = mv[0] && mld[0] && mrd[0] != 0 &&
             ((u1 && r1 == mrd[0]) || (u2 && r2 == mrd[0]));
        e = '0;
        e.pc_en = 1;
        e.ifid_en = 1;
        if (rst) begin
        end else if (mem_busy) begin
            e.pc_en = 0;
            e.ifid_en = 0;
            e.win = 2'd1;
        end else if (ex_redirect && mv[0]) begin
            e.ifid_flush = 1;
            e.idex_flush = 1;
            e.win = 2'd2;
        end else if (lu) begin
            e.pc_en = 0;
            e.ifid_en = 0;
            e.idex_flush = 1;
            e.win = 2'd3;
        end
        e.fa = mfwd(xu1, xrs1);
        e.fb = mfwd(xu2, xrs2);
        return e;
    endfunction

    initial begin
        forever begin
            exp_t e;
            logic [4:0] r1, r2, rd;
            bit u1, u2, wr, ld;
            @(posedge clk);
            e = expect_now();
            dec(id_instr, id_valid, r1, r2, rd, u1, u2, wr, ld);
            if (rst) begin
                for (int k = 0; k < 3; k++) begin
                    mv[k] = 0; mrd[k] = 0; mwr[k] = 0; mld[k] = 0;
                end
                xrs1 = 0; xrs2 = 0; xu1 = 0; xu2 = 0;
                mstall = 0;
                mflush = 0;
            end else if (!mem_busy) begin
                for (int k = 2; k > 0; k--) begin
                    mv[k] = mv[k-1]; mrd[k] = mrd[k-1];
                    mwr[k] = mwr[k-1]; mld[k] = mld[k-1];
                end
                if (e.idex_flush) begin
                    mv[0] = 0; mrd[0] = 0; mwr[0] = 0; mld[0] = 0;
                    xrs1 = 0; xrs2 = 0; xu1 = 0; xu2 = 0;
                end else begin
                    mv[0] = id_valid; mrd[0] = rd;
                    mwr[0] = wr; mld[0] = ld;
                    xrs1 = r1; xrs2 = r2; xu1 = u1; xu2 = u2;
                end
                if (e.win == 2'd3 && mstall < int'(SAT)) mstall++;
                if (e.win == 2'd2 && mflush < int'(SAT)) mflush++;
            end
            chk_en = 1;
        end
    end

    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (chk_en) begin
                e = expect_now();
                check("pc_en", pc_en, e.pc_en);
                check("ifid_en", ifid_en, e.ifid_en);
                check("ifid_flush", ifid_flush, e.ifid_flush);
                check("idex_flush", idex_flush, e.idex_flush);
                check("fwd_a", fwd_a, e.fa);
                check("fwd_b", fwd_b, e.fb);
                check("stall_cnt", stall_cnt, mstall);
                check("flush_cnt", flush_cnt, mflush);
            end
        end
    end

    task automatic cyc(input logic [31:0] ins, input logic v,
                       input logic redir, input logic busy,
                       input logic r);
        @(posedge clk);
        #1;
        id_instr = ins;
        id_valid = v;
        ex_redirect = redir;
        mem_busy = busy;
        rst = r;
        @(negedge clk);
        #1;
    endtask

    task automatic op(input logic [31:0] ins);
        cyc(ins, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not end, limit 500000 reached");
        $fatal(1);
    end

    initial begin
        rst = 1;
        id_instr = NOP;
        id_valid = 0;
        ex_redirect = 0;
        mem_busy = 0;
        cyc(NOP, 0, 0, 0, 1);
        cyc(NOP, 0, 0, 0, 1);
        check("rst_pc_en", pc_en, 1);
        check("rst_ifid_en", ifid_en, 1);
        check("rst_fwd_a", fwd_a, 0);
        check("rst_stall_cnt", stall_cnt, 0);

        // load-use
        op(LW5);
        op(ADD6);
        check("lu_pc_en", pc_en, 0);
        check("lu_idex_flush", idex_flush, 1);
        check("lu_ifid_flush", ifid_flush, 0);
        op(ADD6);
        check("lu_release", pc_en, 1);
        op(NOP);
        check("lu_fwd_a", fwd_a, 2'b10);
        check("lu_fwd_b", fwd_b, 2'b00);
        check("lu_stall_cnt", stall_cnt, 1);
        op(NOP);
        op(NOP);

        // ALU back-to-back
        op(ADDI3);
        op(SUB4);
        check("alu_pc_en", pc_en, 1);
        check("alu_idex_flush", idex_flush, 0);
        op(NOP);
        check("alu_fwd_a", fwd_a, 2'b01);
        check("alu_fwd_b", fwd_b, 2'b01);
        op(NOP);
        op(NOP);

        // destination x0
        op(ADDI0);
        op(ADD7);
        check("x0_pc_en", pc_en, 1);
        op(NOP);
        check("x0_fwd_a", fwd_a, 2'b00);
        check("x0_fwd_b", fwd_b, 2'b00);
        op(NOP);
        op(NOP);

        // redirect squashes two younger instructions
        op(BEQ);
        cyc(ADDI8, 1, 1, 0, 0);
        check("rd_ifid_flush", ifid_flush, 1);
        check("rd_idex_flush", idex_flush, 1);
        check("rd_pc_en", pc_en, 1);
        cyc(NOP, 0, 1, 0, 0);
        check("rd_once_ifid", ifid_flush, 0);
        check("rd_once_idex", idex_flush, 0);
        check("rd_flush_cnt", flush_cnt, 1);
        op(ADD9);
        op(NOP);
        check("rd_squash_fa", fwd_a, 2'b00);
        check("rd_squash_fb", fwd_b, 2'b00);

        // mem_busy over a pending load-use
        op(LW5);
        repeat (3) begin
            cyc(ADD6, 1, 0, 1, 0);
            check("busy_pc_en", pc_en, 0);
            check("busy_idex_flush", idex_flush, 0);
            check("busy_stall_cnt", stall_cnt, 1);
        end
        op(ADD6);
        check("busy_lu_flush", idex_flush, 1);
        check("busy_lu_pc_en", pc_en, 0);
        op(ADD6);
        check("busy_after", pc_en, 1);
        check("busy_stall_cnt2", stall_cnt, 2);

        // redirect and load-use together
        op(LW5);
        cyc(ADD6, 1, 1, 0, 0);
        check("co_ifid_flush", ifid_flush, 1);
        check("co_pc_en", pc_en, 1);
        op(NOP);
        check("co_stall_cnt", stall_cnt, 2);
        check("co_flush_cnt", flush_cnt, 2);

        // reset during a stall
        op(LW5);
        cyc(ADD6, 1, 0, 0, 1);
        check("rs_pc_en", pc_en, 1);
        check("rs_idex_flush", idex_flush, 0);
        op(ADD6);
        check("rs_after_pc_en", pc_en, 1);
        check("rs_stall_cnt", stall_cnt, 0);
        check("rs_flush_cnt", flush_cnt, 0);

        // saturation
        op(LW5);
        repeat (600) op(LW55);
        check("sat_stall_cnt", stall_cnt, SAT);
        repeat (600) cyc(NOP, 1, 1, 0, 0);
        check("sat_flush_cnt", flush_cnt, SAT);
        check("sat_stall_hold", stall_cnt, SAT);
        op(LW5);
        cyc(LW55, 1, 0, 0, 1);
        check("sat_rst_pc_en", pc_en, 1);
        op(NOP);
        check("sat_rst_pc_en2", pc_en, 1);
        check("sat_rst_stall", stall_cnt, 0);
        check("sat_rst_flush", flush_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 The block SHALL have port `clk`, input, 1 bit: rising-edge clock.
REQ-003 The block SHALL have port `rst`, input, 1 bit: synchronous active-high reset.
REQ-004 The block SHALL have port `id_instr`, input, 32 bits: instruction currently in Decode.
REQ-005 The block SHALL have port `id_valid`, input, 1 bit: `id_instr` is a real instruction; 0 means bubble.
REQ-006 The block SHALL have port `ex_redirect`, input, 1 bit: the instruction in Execute is a taken branch, jal or jalr.
REQ-007 The block SHALL have port `mem_busy`, input, 1 bit: data memory not ready; the whole pipeline must hold.
REQ-008 The block SHALL have ports `pc_en` and `ifid_en`, output, 1 bit each: PC and IF/ID register write enables.
REQ-009 The block SHALL have ports `ifid_flush` and `idex_flush`, output, 1 bit each: insert a bubble into IF/ID and ID/EX respectively.
REQ-010 The block SHALL have ports `fwd_a` and `fwd_b`, output, 2 bits each: ALU operand source for the instruction in Execute.
- 00 = register file
- 01 = MEM-stage result
- 10 = WB-stage result
REQ-011 The block SHALL have ports `stall_cnt` and `flush_cnt`, output, 16 bits each: saturating performance counters.

Function
REQ-012 The decoder SHALL extract from `id_instr`: rs1[19:15], rs2[24:20], rd[11:7] and opcode[6:2].
REQ-013 uses_rs1 SHALL be 1 for opcodes 01100, 00100, 00000, 11001, 01000 and 11000.
REQ-014 uses_rs2 SHALL be 1 for opcodes 01100, 01000 and 11000.
REQ-015 writes_rd SHALL be 1 for opcodes 01100, 00100, 00000, 11001, 00101, 01101 and 11011, and only when rd != 0.
REQ-016 is_load SHALL be 1 for opcode 00000.
REQ-017 All decoded flags SHALL be forced to 0 when `id_valid` = 0.
REQ-018 The block SHALL hold three shadow stage registers, EX, MEM and WB.
- Each holds {valid, rd, regwrite, memread}.
- EX additionally holds rs1, rs2, uses_rs1 and uses_rs2.
REQ-019 load_use SHALL be 1 when all of the following hold:
- EX.valid, EX.memread and EX.rd != 0;
- ((uses_rs1 && rs1 == EX.rd) || (uses_rs2 && rs2 == EX.rd)).
REQ-020 redirect SHALL be `ex_redirect` && EX.valid; `ex_redirect` SHALL be ignored when EX.valid = 0.
REQ-021 Control outputs SHALL be resolved with priority rst > mem_busy > redirect > load_use > normal, as follows:
- rst: pc_en = 1, ifid_en = 1, both flushes = 0.
- mem_busy: pc_en = 0, ifid_en = 0, both flushes = 0; all shadow registers and counters hold.
- redirect: pc_en = 1, ifid_en = 1, ifid_flush = 1, idex_flush = 1.
- load_use: pc_en = 0, ifid_en = 0, ifid_flush = 0, idex_flush = 1.
- normal: pc_en = 1, ifid_en = 1, both flushes = 0.
REQ-022 When not under mem_busy, the shadow registers SHALL update on each clock edge:
- WB <= MEM;
- MEM <= EX;
- EX <= bubble (valid = 0) if idex_flush, otherwise EX <= the decoded Decode instruction.
REQ-023 Control outputs SHALL be combinational from the current state and inputs, giving zero-cycle latency.
REQ-024 A load-use stall SHALL last exactly one cycle; a redirect SHALL squash exactly two younger instructions.
REQ-025 `fwd_a` SHALL be computed as follows (first match wins):
- 01 if EX.uses_rs1 && MEM.valid && MEM.regwrite && !MEM.memread && MEM.rd == EX.rs1;
- 10 if EX.uses_rs1 && WB.valid && WB.regwrite && WB.rd == EX.rs1;
- 00 otherwise.
REQ-026 `fwd_b` SHALL be computed the same way as `fwd_a`, using rs2 and uses_rs2.
REQ-027 `fwd_a` and `fwd_b` SHALL be 00 when EX.valid = 0.
REQ-028 `stall_cnt` SHALL increment on each non-reset cycle in which load_use is the winning condition, and saturate at 0xFFFF.
REQ-029 `flush_cnt` SHALL increment on each non-reset cycle in which redirect is the winning condition, and saturate at 0xFFFF.
REQ-030 When redirect and load_use coincide, only redirect SHALL act, and only `flush_cnt` increments.

Reset
REQ-031 On a clock edge with `rst` = 1, the block SHALL clear EX/MEM/WB.valid and all their fields, and set both counters to 0.
REQ-032 Outputs during and after reset SHALL be pc_en = 1, ifid_en = 1, flushes = 0, fwd_a = fwd_b = 00.
REQ-033 Reset asserted mid-stall or mid-flush SHALL override it, with no residual stall in the following cycle.

Structure
REQ-034 A shared package SHALL define the following:
- opcode constants (OP_R = 01100, OP_I = 00100, OP_LOAD = 00000, OP_JALR = 11001, OP_S = 01000, OP_B = 11000, OP_AUIPC = 00101, OP_LUI = 01101, OP_JAL = 11011);
- forwarding encodings FWD_RF, FWD_MEM and FWD_WB;
- the stage-record typedef.
REQ-035 The block SHALL contain one sub-module, hazard_decode, implementing REQ-012 to REQ-017.

Verification
REQ-036 Load-use: `lw x5,0(x1)` then `add x6,x5,x2` -> one cycle with pc_en = 0 and idex_flush = 1; when the add is in EX, fwd_a = 10; stall_cnt = 1.
REQ-037 ALU back-to-back: `addi x3,x0,7` then `sub x4,x3,x3` -> no stall; fwd_a = fwd_b = 01 when the sub is in EX.
REQ-038 Redirect: `beq` in EX with `ex_redirect` = 1 -> ifid_flush = idex_flush = 1 for exactly one cycle; flush_cnt = 1; the two following instructions never reach MEM.
REQ-039 Destination x0: `addi x0,x0,1` then `add x7,x0,x0` -> fwd_a = fwd_b = 00, no stall.
REQ-040 mem_busy held 3 cycles during a pending load-use -> pc_en = 0 and no counter change during those cycles; a single stall cycle follows.
REQ-041 Saturation and reset: force 0x10000 load-use events -> stall_cnt = 0xFFFF; assert `rst` during a stall -> next cycle pc_en = 1 and counters = 0.
